// File: rtl/md5_block_packer.sv
// md5_block_packer: packs typed bytes into padded hash blocks and hands them out over valid/ready
module md5_block_packer #(
  parameter int          BLOCK_BYTES    = 64,
  parameter int          LEN_BYTES      = 8,
  parameter bit          LEN_BIG_ENDIAN = 0,
  parameter logic [7:0]  DEL_CODE       = 8'h08,
  parameter logic [7:0]  END_CODE       = 8'h0d
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [7:0]               ascii,
  output logic                     in_ready,
  output logic                     dropped,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic                     blk_first,
  output logic                     blk_last,
  output logic                     msg_done
);
  localparam int PW = $clog2(BLOCK_BYTES);
  localparam int TW = 8*LEN_BYTES-3;
  localparam logic [PW-1:0] P_LAST = PW'(BLOCK_BYTES-1);
  localparam logic [PW-1:0] P_FIT  = PW'(BLOCK_BYTES-LEN_BYTES-1);

  typedef enum logic [2:0] {COLLECT, PAD, SEND_DATA, SEND_PAD, LENBLK, SEND_LAST} state_t;

  state_t                           r_state;
  logic [BLOCK_BYTES-1:0][7:0]      r_buf;
  logic [PW-1:0]                    r_ptr;
  logic [TW-1:0]                    r_total;
  logic                             r_first;
  logic                             r_dropped;
  logic                             r_msg_done;
  logic [LEN_BYTES-1:0][7:0]        w_bits;
  logic [LEN_BYTES-1:0][7:0]        w_len;

  assign in_ready  = r_state == COLLECT;
  assign blk_valid = r_state == SEND_DATA || r_state == SEND_PAD || r_state == SEND_LAST;
  assign blk_last  = r_state == SEND_LAST;
  assign blk_first = r_first;
  assign blk_data  = r_buf;
  assign dropped   = r_dropped;
  assign msg_done  = r_msg_done;

  // message bit length laid out in the selected byte order for the top of the block
  always_comb begin
    w_bits = {r_total, 3'b000};
    for (int j = 0; j < LEN_BYTES; j++) w_len[j] = LEN_BIG_ENDIAN ? w_bits[LEN_BYTES-1-j] : w_bits[j];
  end

  // collection, padding and block handoff state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= COLLECT;
      r_buf      <= '0;
      r_ptr      <= '0;
      r_total    <= '0;
      r_first    <= 1'b1;
      r_dropped  <= 1'b0;
      r_msg_done <= 1'b0;
    end else begin
      r_dropped  <= en && ascii != 8'h00 && r_state != COLLECT;
      r_msg_done <= r_state == SEND_LAST && blk_ready;
      case (r_state)
        COLLECT: if (en && ascii != 8'h00) begin
          if (ascii == DEL_CODE) begin
            if (r_ptr != '0) begin
              r_ptr              <= r_ptr - 1'b1;
              r_total            <= r_total - 1'b1;
              r_buf[r_ptr - 1'b1] <= 8'h00;
            end
          end else if (ascii == END_CODE) begin
            r_state <= PAD;
          end else begin
            r_buf[r_ptr] <= ascii;
            r_total      <= r_total + 1'b1;
            r_ptr        <= r_ptr == P_LAST ? '0 : r_ptr + 1'b1;
            if (r_ptr == P_LAST) r_state <= SEND_DATA;
          end
        end
        PAD: begin
          r_buf[r_ptr] <= 8'h80;
          if (r_ptr <= P_FIT) begin
            r_buf[BLOCK_BYTES-1:BLOCK_BYTES-LEN_BYTES] <= w_len;
            r_state <= SEND_LAST;
          end else begin
            r_state <= SEND_PAD;
          end
        end
        SEND_DATA, SEND_PAD: if (blk_ready) begin
          r_buf   <= '0;
          r_ptr   <= '0;
          r_first <= 1'b0;
          r_state <= r_state == SEND_DATA ? COLLECT : LENBLK;
        end
        LENBLK: begin
          r_buf[BLOCK_BYTES-1:BLOCK_BYTES-LEN_BYTES] <= w_len;
          r_state <= SEND_LAST;
        end
        SEND_LAST: if (blk_ready) begin
          r_buf   <= '0;
          r_ptr   <= '0;
          r_total <= '0;
          r_first <= 1'b1;
          r_state <= COLLECT;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_block_packer.sv
// tb_md5_block_packer: directed table and sequence checks of little- and big-endian-length packers
module tb_md5_block_packer;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [7:0]   ascii = 8'h00;
  logic         blk_ready = 1'b0;
  logic         in_ready, dropped, blk_valid, blk_first, blk_last, msg_done;
  logic [511:0] blk_data;
  logic         be_in_ready, be_dropped, be_valid, be_first, be_last, be_done;
  logic [511:0] be_data;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  md5_block_packer dut (
    .clk(clk), .reset(reset), .en(en), .ascii(ascii), .in_ready(in_ready), .dropped(dropped),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_first(blk_first),
    .blk_last(blk_last), .msg_done(msg_done)
  );

  md5_block_packer #(.LEN_BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset(reset), .en(en), .ascii(ascii), .in_ready(be_in_ready), .dropped(be_dropped),
    .blk_valid(be_valid), .blk_ready(blk_ready), .blk_data(be_data), .blk_first(be_first),
    .blk_last(be_last), .msg_done(be_done)
  );

  typedef struct {
    int           n_a;
    string        keys;
    int           nblk;
    logic [511:0] le0, le1, be0, be1;
    bit           f0, l0, f1, l1;
  } vec_t;

  vec_t vt[8];

  logic [511:0] cap_le[4], cap_be[4];
  bit           cap_f[4], cap_l[4];
  int           ncap, ndone, ndrop;

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic string rep(int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, "a"};
    return r;
  endfunction

  function automatic logic [511:0] blk(string s, int i0 = -1, int v0 = 0, int i1 = -1, int v1 = 0,
                                       int i2 = -1, int v2 = 0);
    logic [511:0] b = '0;
    for (int i = 0; i < s.len(); i++) b[8*i +: 8] = s[i];
    if (i0 >= 0) b[8*i0 +: 8] = 8'(v0);
    if (i1 >= 0) b[8*i1 +: 8] = 8'(v1);
    if (i2 >= 0) b[8*i2 +: 8] = 8'(v2);
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[k]) begin
      int w = 0;
      en = 1'b0;
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) chk("in_ready_timeout", {511'b0, in_ready}, 512'd1);
      en = 1'b1;
      ascii = q[k];
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic run_msg(input logic [7:0] q[$]);
    ncap = 0;
    ndone = 0;
    ndrop = 0;
    for (int i = 0; i < 4; i++) begin
      cap_le[i] = '0;
      cap_be[i] = '0;
      cap_f[i] = 1'b0;
      cap_l[i] = 1'b0;
    end
    fork
      send_bytes(q);
      begin
        repeat (q.size() + 40) begin
          @(negedge clk);
          if (blk_valid && blk_ready) begin
            if (ncap < 4) begin
              cap_le[ncap] = blk_data;
              cap_be[ncap] = be_data;
              cap_f[ncap] = blk_first;
              cap_l[ncap] = blk_last;
            end
            ncap++;
          end
          if (msg_done) ndone++;
          if (dropped) ndrop++;
        end
      end
    join
  endtask

  initial begin
    logic [7:0]   q[$];
    logic [511:0] d0;
    bit           f0, l0;
    int           w;

    vt[0] = '{0, "abc", 1, blk("abc", 3, 'h80, 56, 'h18), '0, blk("abc", 3, 'h80, 63, 'h18), '0, 1, 1, 0, 0};
    vt[1] = '{55, "", 1, blk(rep(55), 55, 'h80, 56, 'hB8, 57, 1), '0,
              blk(rep(55), 55, 'h80, 62, 1, 63, 'hB8), '0, 1, 1, 0, 0};
    vt[2] = '{56, "", 2, blk(rep(56), 56, 'h80), blk("", 56, 'hC0, 57, 1),
              blk(rep(56), 56, 'h80), blk("", 62, 1, 63, 'hC0), 1, 0, 0, 1};
    vt[3] = '{64, "", 2, blk(rep(64)), blk("", 0, 'h80, 57, 2),
              blk(rep(64)), blk("", 0, 'h80, 62, 2), 1, 0, 0, 1};
    vt[4] = '{0, "ab\010c", 1, blk("ac", 2, 'h80, 56, 'h10), '0, blk("ac", 2, 'h80, 63, 'h10), '0, 1, 1, 0, 0};
    vt[5] = '{0, "\010xy", 1, blk("xy", 2, 'h80, 56, 'h10), '0, blk("xy", 2, 'h80, 63, 'h10), '0, 1, 1, 0, 0};
    vt[6] = '{0, "", 1, blk("", 0, 'h80), '0, blk("", 0, 'h80), '0, 1, 1, 0, 0};
    vt[7] = '{0, "a\010\010z", 1, blk("z", 1, 'h80, 56, 8), '0, blk("z", 1, 'h80, 63, 8), '0, 1, 1, 0, 0};

    do_reset();
    chk("rst_in_ready", {511'b0, in_ready}, 512'd1);
    chk("rst_valid", {511'b0, blk_valid}, 512'd0);
    chk("rst_first", {511'b0, blk_first}, 512'd1);
    chk("rst_last", {511'b0, blk_last}, 512'd0);
    chk("rst_dropped", {511'b0, dropped}, 512'd0);
    chk("rst_msg_done", {511'b0, msg_done}, 512'd0);
    chk("rst_data", blk_data, '0);

    blk_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      do_reset();
      q.delete();
      for (int i = 0; i < vt[v].n_a; i++) q.push_back("a");
      for (int i = 0; i < vt[v].keys.len(); i++) q.push_back(vt[v].keys[i]);
      q.push_back(8'h0d);
      run_msg(q);
      chk($sformatf("v%0d_nblk", v), 512'(ncap), 512'(vt[v].nblk));
      chk($sformatf("v%0d_done", v), 512'(ndone), 512'd1);
      chk($sformatf("v%0d_le0", v), cap_le[0], vt[v].le0);
      chk($sformatf("v%0d_be0", v), cap_be[0], vt[v].be0);
      chk($sformatf("v%0d_f0", v), {511'b0, cap_f[0]}, {511'b0, vt[v].f0});
      chk($sformatf("v%0d_l0", v), {511'b0, cap_l[0]}, {511'b0, vt[v].l0});
      if (vt[v].nblk > 1) begin
        chk($sformatf("v%0d_le1", v), cap_le[1], vt[v].le1);
        chk($sformatf("v%0d_be1", v), cap_be[1], vt[v].be1);
        chk($sformatf("v%0d_f1", v), {511'b0, cap_f[1]}, {511'b0, vt[v].f1});
        chk($sformatf("v%0d_l1", v), {511'b0, cap_l[1]}, {511'b0, vt[v].l1});
      end
    end

    do_reset();
    q = '{8'h61, 8'h00, 8'h62, 8'h0d};
    run_msg(q);
    chk("nul_data", cap_le[0], blk("ab", 2, 'h80, 56, 'h10));
    chk("nul_no_drop", 512'(ndrop), 512'd0);

    do_reset();
    blk_ready = 1'b0;
    q = '{8'h78, 8'h79, 8'h0d};
    send_bytes(q);
    chk("bp_pad_cycle_valid", {511'b0, blk_valid}, 512'd0);
    @(negedge clk);
    chk("bp_valid_after_pad", {511'b0, blk_valid}, 512'd1);
    d0 = blk_data;
    f0 = blk_first;
    l0 = blk_last;
    chk("bp_data", d0, blk("xy", 2, 'h80, 56, 'h10));
    for (int c = 0; c < 5; c++) begin
      en = c == 1;
      ascii = 8'h7a;
      @(negedge clk);
      en = 1'b0;
      if (c == 1) chk("bp_dropped", {511'b0, dropped}, 512'd1);
      chk($sformatf("bp_hold_data_%0d", c), blk_data, d0);
      chk($sformatf("bp_hold_fl_%0d", c), {510'b0, blk_first, blk_last}, {510'b0, f0, l0});
      chk($sformatf("bp_hold_valid_%0d", c), {511'b0, blk_valid}, 512'd1);
    end
    chk("bp_first_last", {510'b0, f0, l0}, {510'b0, 2'b11});
    blk_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", {511'b0, blk_valid}, 512'd0);
    chk("bp_msg_done", {511'b0, msg_done}, 512'd1);
    @(negedge clk);
    chk("bp_msg_done_pulse", {511'b0, msg_done}, 512'd0);

    do_reset();
    blk_ready = 1'b0;
    q = '{8'h71, 8'h0d};
    send_bytes(q);
    w = 0;
    while (!blk_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("rh_valid_before", {511'b0, blk_valid}, 512'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rh_valid", {511'b0, blk_valid}, 512'd0);
    chk("rh_in_ready", {511'b0, in_ready}, 512'd1);
    chk("rh_data", blk_data, '0);
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
